// File: rtl/cursor_blink.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_blink
//  Description : Free-running square-wave blink generator for the text-console
//                cursor. flash_on is a registered level that toggles every
//                HALF_PERIOD enabled clocks; tick pulses for one cycle in the
//                cycle flash_on toggles on timeout. A restart pulse (keystroke)
//                forces the cursor visible and restarts the phase.
//  Ports       : clk      - pixel clock, rising-edge active
//                clrn     - asynchronous active-low reset
//                en       - blink enable; low hides the cursor, clears counter
//                restart  - synchronous restart, cursor shown immediately
//                flash_on - registered cursor-visible level
//                tick     - registered one-cycle toggle-on-timeout pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_blink #(
  parameter int HALF_PERIOD = 12500000,          // clocks per half blink; >= 2
  parameter int CNT_W       = $clog2(HALF_PERIOD) // derived, do not override
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic restart,
  output logic flash_on,
  output logic tick
);

  // Terminal count. HALF_PERIOD-1 always fits in $clog2(HALF_PERIOD) bits,
  // so the counter wraps explicitly here and never by overflow.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             flash_q, flash_d;
  logic             tick_q,  tick_d;

  // Priority: en low > restart > terminal count > count.
  always_comb begin
    cnt_d   = cnt_q;
    flash_d = flash_q;
    tick_d  = 1'b0;
    if (!en) begin
      cnt_d   = '0;
      flash_d = 1'b0;
    end else if (restart) begin
      // Restart beats a coincident timeout: no toggle, cursor shown.
      cnt_d   = '0;
      flash_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      flash_d = ~flash_q;
      tick_d  = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q   <= '0;
      flash_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      tick_q  <= tick_d;
    end
  end

  assign flash_on = flash_q;
  assign tick     = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_cursor_blink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cursor_blink
//  Description : Self-checking bench for cursor_blink (HALF_PERIOD = 4).
//                A phase-based reference model predicts flash_on/tick on every
//                cycle; a directed table pins the model with literal values,
//                followed by an asynchronous reset and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_blink;

  localparam int HP = 4;

  logic clk = 1'b0;
  logic clrn;
  logic en;
  logic restart;
  logic flash_on;
  logic tick;

  int n_checks = 0;
  int n_pass   = 0;

  cursor_blink #(.HALF_PERIOD(HP)) u_dut (
    .clk      (clk),
    .clrn     (clrn),
    .en       (en),
    .restart  (restart),
    .flash_on (flash_on),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: the output is a function of the level set at the last
  // phase anchor (reset, en low, restart) and the number of counting edges
  // elapsed since that anchor.
  // --------------------------------------------------------------------------
  int m_e   = 0;   // counting edges since anchor
  bit m_lvl = 0;   // flash level at the anchor

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_e = 0; m_lvl = 0;
    end else if (!en) begin
      m_e = 0; m_lvl = 0;
    end else if (restart) begin
      m_e = 0; m_lvl = 1;
    end else begin
      m_e = m_e + 1;
    end
  end

  function automatic bit exp_flash();
    return m_lvl ^ (((m_e / HP) % 2) == 1);
  endfunction

  function automatic bit exp_tick();
    return (m_e > 0) && ((m_e % HP) == 0);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  bit run_cmp = 0;
  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_flash_on", flash_on, exp_flash());
      check("model_tick",     tick,     exp_tick());
    end
  end

  // Directed table: {en, restart, expected flash_on, expected tick} per edge.
  function automatic logic [3:0] dir_row(input int k);
    case (k)
      1, 2, 3:     return 4'b1000;
      4:           return 4'b1011;   // first toggle after HP edges
      5, 6, 7:     return 4'b1010;
      8:           return 4'b1001;   // falls, tick
      9, 10:       return 4'b1000;   // cnt 1, 2
      11:          return 4'b1110;   // restart mid-phase -> visible
      12, 13, 14:  return 4'b1010;   // cnt 1..3
      15:          return 4'b1110;   // restart at terminal count wins
      16:          return 4'b1010;
      17:          return 4'b0000;   // en low while visible -> hidden
      18:          return 4'b0100;   // restart ignored while disabled
      19, 20, 21:  return 4'b1000;
      22:          return 4'b1011;   // toggles after exactly HP edges
      default:     return 4'b1000;
    endcase
  endfunction

  initial begin
    logic [3:0] row;
    int         guard;

    clrn = 1'b0; en = 1'b1; restart = 1'b0;
    run_cmp = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flash_on", flash_on, 1'b0);
    check("reset_tick",     tick,     1'b0);

    @(negedge clk);
    clrn = 1'b1;

    for (int k = 1; k <= 22; k++) begin
      row     = dir_row(k);
      en      = row[3];
      restart = row[2];
      @(posedge clk);
      #1;
      check($sformatf("dir_flash_e%0d", k), flash_on, row[1]);
      check($sformatf("dir_tick_e%0d",  k), tick,     row[0]);
      @(negedge clk);
    end
    en = 1'b1; restart = 1'b0;

    // Asynchronous reset between edges while the cursor is visible.
    guard = 0;
    while (flash_on !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("async_pre_visible", flash_on, 1'b1);
    @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    check("async_flash_on", flash_on, 1'b0);
    check("async_tick",     tick,     1'b0);
    @(negedge clk);
    clrn = 1'b1;
    for (int k = 1; k <= HP; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_flash_e%0d", k), flash_on, (k == HP) ? 1'b1 : 1'b0);
    end
    @(negedge clk);

    // Randomized traffic, including multi-cycle restart holds.
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 24) != 0);
      if (restart && $urandom_range(0, 2) != 0) restart = 1'b1;
      else restart = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    en = 1'b1; restart = 1'b0;
    repeat (3 * HP) @(negedge clk);

    run_cmp = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
